// File: rtl/mmio_ws_controller.sv
// -----------------------------------------------------------------------------
// mmio_ws_controller
//
// Decodes the CPU MMIO bus into N_SLOT peripheral slots. A peripheral may
// stretch an access with wait states by holding its slot_ready low. A
// watchdog ends the access with an error after TIMEOUT cycles. Accesses to
// unpopulated slots, and requests with an ambiguous opcode (rd == wr), fail
// at once and never reach a slot. Every completion gives a one-cycle
// mmio_ready pulse with registered read data. Failed accesses also set
// mmio_err and return UNMAP_DATA.
//
// Ports
//   clk, reset        : clock and synchronous active-low reset
//   mmio_cs/rd/wr     : request valid and opcode (sampled only when idle)
//   mmio_addr         : {ignored, slot index, register offset}
//   mmio_wr_data      : write data
//   mmio_rd_data      : read data, valid with mmio_ready, held afterwards
//   mmio_ready        : one-cycle completion pulse
//   mmio_err          : qualifies mmio_ready, access failed
//   busy              : an access is in progress (ACCESS/RESP)
//   err_cnt           : saturating count of failed accesses
//   slot_cs           : one-hot slot select
//   slot_rd/slot_wr   : strobes to the selected slot
//   slot_addr         : register offset inside the slot
//   slot_wr_data      : write data to the slot
//   slot_rd_data      : flattened slot read data, slot i at [32*i +: 32]
//   slot_ready        : per-slot completion handshake
// -----------------------------------------------------------------------------
module mmio_ws_controller #(
   parameter int                N_SLOT     = 64,
   parameter int                REG_AW     = 5,
   parameter int                ADDR_W     = 21,
   parameter logic [N_SLOT-1:0] SLOT_MASK  = {N_SLOT{1'b1}},
   parameter int                TIMEOUT    = 15,
   parameter logic [31:0]       UNMAP_DATA = 32'hFFFF_FFFF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mmio_cs,
   input  logic                   mmio_wr,
   input  logic                   mmio_rd,
   input  logic [ADDR_W-1:0]      mmio_addr,
   input  logic [31:0]            mmio_wr_data,
   output logic [31:0]            mmio_rd_data,
   output logic                   mmio_ready,
   output logic                   mmio_err,
   output logic                   busy,
   output logic [7:0]             err_cnt,
   output logic [N_SLOT-1:0]      slot_cs,
   output logic                   slot_rd,
   output logic                   slot_wr,
   output logic [REG_AW-1:0]      slot_addr,
   output logic [31:0]            slot_wr_data,
   input  logic [N_SLOT*32-1:0]   slot_rd_data,
   input  logic [N_SLOT-1:0]      slot_ready
);

   localparam int         IDX_W   = $clog2(N_SLOT);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t           state_r;
   logic [IDX_W-1:0] idx_r;      // slot index latched at acceptance
   logic             op_wr_r;    // latched opcode: 1 = write
   logic [7:0]       cnt_r;      // wait-state counter in ACCESS

   logic [IDX_W-1:0]  acc_idx_s;
   logic [REG_AW-1:0] acc_reg_s;
   logic              legal_op_s;
   logic              mapped_s;
   logic              sel_ready_s;
   logic [31:0]       sel_data_s;
   logic              timeout_s;
   logic              unused_addr_s;

   // One-hot select vector for a slot index.
   function automatic logic [N_SLOT-1:0] slot_onehot(input logic [IDX_W-1:0] idx);
      logic [N_SLOT-1:0] v;
      v      = {N_SLOT{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   // Saturating 8-bit increment.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

   // Address bits above the slot index carry no meaning for this block.
   assign unused_addr_s = ^mmio_addr;

   // Request decode and selected-slot response mux.
   always_comb begin
      acc_idx_s   = mmio_addr[REG_AW +: IDX_W];
      acc_reg_s   = mmio_addr[REG_AW-1:0];
      legal_op_s  = mmio_rd ^ mmio_wr;
      mapped_s    = SLOT_MASK[acc_idx_s];
      // Only the latched slot may complete the access; others are ignored.
      sel_ready_s = slot_ready[idx_r];
      sel_data_s  = slot_rd_data[{idx_r, 5'b00000} +: 32];
      timeout_s   = (cnt_r == TO_LAST);
   end

   // Access FSM with all bus and slot outputs registered.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         idx_r        <= {IDX_W{1'b0}};
         op_wr_r      <= 1'b0;
         cnt_r        <= 8'd0;
         mmio_rd_data <= 32'd0;
         mmio_ready   <= 1'b0;
         mmio_err     <= 1'b0;
         busy         <= 1'b0;
         err_cnt      <= 8'd0;
         slot_cs      <= {N_SLOT{1'b0}};
         slot_rd      <= 1'b0;
         slot_wr      <= 1'b0;
         slot_addr    <= {REG_AW{1'b0}};
         slot_wr_data <= 32'd0;
      end else begin
         // The completion pulse lasts one cycle unless set again below.
         mmio_ready <= 1'b0;
         mmio_err   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (mmio_cs) begin
                  busy    <= 1'b1;
                  idx_r   <= acc_idx_s;
                  op_wr_r <= mmio_wr;
                  if (legal_op_s && mapped_s) begin
                     state_r      <= ST_ACCESS;
                     cnt_r        <= 8'd0;
                     slot_cs      <= slot_onehot(acc_idx_s);
                     slot_rd      <= mmio_rd;
                     slot_wr      <= mmio_wr;
                     slot_addr    <= acc_reg_s;
                     slot_wr_data <= mmio_wr_data;
                  end else begin
                     // Rejected without touching the slot side.
                     state_r      <= ST_RESP;
                     mmio_ready   <= 1'b1;
                     mmio_err     <= 1'b1;
                     mmio_rd_data <= UNMAP_DATA;
                     err_cnt      <= sat_inc8(err_cnt);
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end

            ST_ACCESS: begin
               if (sel_ready_s) begin
                  state_r      <= ST_RESP;
                  slot_cs      <= {N_SLOT{1'b0}};
                  slot_rd      <= 1'b0;
                  slot_wr      <= 1'b0;
                  mmio_ready   <= 1'b1;
                  mmio_err     <= 1'b0;
                  mmio_rd_data <= op_wr_r ? 32'd0 : sel_data_s;
               end else if (timeout_s) begin
                  state_r      <= ST_RESP;
                  slot_cs      <= {N_SLOT{1'b0}};
                  slot_rd      <= 1'b0;
                  slot_wr      <= 1'b0;
                  mmio_ready   <= 1'b1;
                  mmio_err     <= 1'b1;
                  mmio_rd_data <= UNMAP_DATA;
                  err_cnt      <= sat_inc8(err_cnt);
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end

            ST_RESP: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end

            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
               slot_cs <= {N_SLOT{1'b0}};
               slot_rd <= 1'b0;
               slot_wr <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_ws_controller.sv
// -----------------------------------------------------------------------------
// tb_mmio_ws_controller
//
// Self-checking bench for mmio_ws_controller. Slots are modelled by a
// per-slot wait-state table and data memory. Expected latency, error flag,
// read data and error count come from the controller's access rules.
// -----------------------------------------------------------------------------
module tb_mmio_ws_controller;

   localparam int          N_SLOT  = 64;
   localparam int          REG_AW  = 5;
   localparam int          ADDR_W  = 21;
   localparam int          TIMEOUT = 15;
   localparam logic [31:0] UNMAP   = 32'hFFFF_FFFF;
   // Slots 5 and 40 are unpopulated.
   localparam logic [63:0] MASK    = ~64'h0000_0100_0000_0020;

   logic                  clk;
   logic                  reset;
   logic                  mmio_cs;
   logic                  mmio_wr;
   logic                  mmio_rd;
   logic [ADDR_W-1:0]     mmio_addr;
   logic [31:0]           mmio_wr_data;
   logic [31:0]           mmio_rd_data;
   logic                  mmio_ready;
   logic                  mmio_err;
   logic                  busy;
   logic [7:0]            err_cnt;
   logic [N_SLOT-1:0]     slot_cs;
   logic                  slot_rd;
   logic                  slot_wr;
   logic [REG_AW-1:0]     slot_addr;
   logic [31:0]           slot_wr_data;
   logic [N_SLOT*32-1:0]  slot_rd_data;
   logic [N_SLOT-1:0]     slot_ready;

   mmio_ws_controller #(
      .N_SLOT(N_SLOT), .REG_AW(REG_AW), .ADDR_W(ADDR_W),
      .SLOT_MASK(MASK), .TIMEOUT(TIMEOUT), .UNMAP_DATA(UNMAP)
   ) dut (
      .clk(clk), .reset(reset),
      .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
      .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
      .mmio_rd_data(mmio_rd_data), .mmio_ready(mmio_ready),
      .mmio_err(mmio_err), .busy(busy), .err_cnt(err_cnt),
      .slot_cs(slot_cs), .slot_rd(slot_rd), .slot_wr(slot_wr),
      .slot_addr(slot_addr), .slot_wr_data(slot_wr_data),
      .slot_rd_data(slot_rd_data), .slot_ready(slot_ready)
   );

   int          n_checks;
   int          n_errors;
   int          exp_err_cnt;
   logic [63:0] mask_v;
   int          wait_cfg [N_SLOT];
   logic [31:0] slot_mem [N_SLOT];
   int          acc_cyc;
   logic [63:0] noise;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles the current slot access has been strobed.
   always @(posedge clk) begin
      if (|slot_cs) acc_cyc <= acc_cyc + 1;
      else          acc_cyc <= 0;
   end

   // Random slot_ready noise on slots that are not selected.
   always @(negedge clk) begin
      noise <= {$urandom, $urandom};
   end

   // Slot model: selected slot answers after its configured wait count.
   always_comb begin
      logic [N_SLOT-1:0] sel_rdy;
      sel_rdy = '0;
      for (int i = 0; i < N_SLOT; i++) begin
         sel_rdy[i]              = slot_cs[i] && (acc_cyc >= wait_cfg[i]);
         slot_rd_data[32*i +: 32] = slot_mem[i];
      end
      slot_ready = sel_rdy | (noise & ~slot_cs);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request and check it against the access rules.
   task automatic do_req(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wd, input bit spam);
      int          idx;
      int          exp_lat;
      int          exp_str;
      bit          exp_err;
      logic [31:0] exp_data;
      logic [63:0] exp_cs;
      int          m;
      int          strobes;
      int          bad;
      int          bad_busy;
      bit          got;

      idx    = int'(addr[REG_AW +: 6]);
      exp_cs = 64'd1 << idx;
      if ((rd == wr) || !mask_v[idx]) begin
         exp_err = 1'b1; exp_lat = 1; exp_str = 0; exp_data = UNMAP;
      end else if (wait_cfg[idx] >= TIMEOUT) begin
         exp_err = 1'b1; exp_lat = TIMEOUT + 1; exp_str = TIMEOUT; exp_data = UNMAP;
      end else begin
         exp_err  = 1'b0;
         exp_lat  = wait_cfg[idx] + 2;
         exp_str  = wait_cfg[idx] + 1;
         exp_data = wr ? 32'd0 : slot_mem[idx];
      end
      if (exp_err && exp_err_cnt < 255) exp_err_cnt++;

      @(negedge clk);
      mmio_cs = 1'b1; mmio_rd = rd; mmio_wr = wr; mmio_addr = addr; mmio_wr_data = wd;
      @(posedge clk); #1;
      m = 0; strobes = 0; bad = 0; bad_busy = 0; got = 1'b0;
      while (!got && m < 300) begin
         if (mmio_ready) begin
            got = 1'b1;
         end else begin
            if (slot_cs != '0) begin
               strobes++;
               if (slot_cs !== exp_cs || slot_addr !== addr[REG_AW-1:0] ||
                   slot_rd !== rd || slot_wr !== wr || slot_wr_data !== wd) bad++;
            end
            if (busy !== 1'b1) bad_busy++;
            if (spam) begin
               mmio_cs      = 1'($urandom_range(0, 1));
               mmio_rd      = 1'($urandom_range(0, 1));
               mmio_wr      = 1'($urandom_range(0, 1));
               mmio_addr    = ADDR_W'($urandom);
               mmio_wr_data = $urandom;
            end else begin
               mmio_cs = 1'b0;
            end
            @(posedge clk); #1;
            m++;
         end
      end
      mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
      chk("completed",  64'(got), 64'd1);
      chk("latency",    64'(m + 1), 64'(exp_lat));
      chk("mmio_err",   64'(mmio_err), 64'(exp_err));
      chk("rd_data",    64'(mmio_rd_data), 64'(exp_data));
      chk("err_cnt",    64'(err_cnt), 64'(exp_err_cnt));
      chk("strobe_cyc", 64'(strobes), 64'(exp_str));
      chk("strobe_val", 64'(bad), 64'd0);
      chk("busy_wait",  64'(bad_busy), 64'd0);
      chk("busy_resp",  64'(busy), 64'd1);
      chk("resp_cs",    64'(slot_cs), 64'd0);
      @(posedge clk); #1;
      chk("ready_pulse", 64'(mmio_ready), 64'd0);
      chk("busy_idle",   64'(busy), 64'd0);
      chk("rd_hold",     64'(mmio_rd_data), 64'(exp_data));
   endtask

   initial begin
      n_checks = 0; n_errors = 0; exp_err_cnt = 0; mask_v = MASK;
      acc_cyc = 0;
      for (int i = 0; i < N_SLOT; i++) begin
         wait_cfg[i] = 0;
         slot_mem[i] = 32'hA5A5_0000 | 32'(i);
      end
      reset = 1'b0; mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
      mmio_addr = '0; mmio_wr_data = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready",   64'(mmio_ready), 64'd0);
      chk("rst_err",     64'(mmio_err), 64'd0);
      chk("rst_busy",    64'(busy), 64'd0);
      chk("rst_errcnt",  64'(err_cnt), 64'd0);
      chk("rst_cs",      64'(slot_cs), 64'd0);
      chk("rst_strobe",  64'({slot_rd, slot_wr}), 64'd0);
      chk("rst_saddr",   64'(slot_addr), 64'd0);
      chk("rst_swdata",  64'(slot_wr_data), 64'd0);
      chk("rst_rddata",  64'(mmio_rd_data), 64'd0);
      @(negedge clk); reset = 1'b1;

      // Zero-wait read of slot 3, register 2.
      do_req(1'b1, 1'b0, 21'((3 << REG_AW) | 2), 32'd0, 1'b0);
      // Write to slot 1 with 4 wait states.
      wait_cfg[1] = 4;
      do_req(1'b0, 1'b1, 21'((1 << REG_AW) | 7), 32'h0000_1234, 1'b0);
      // Slot 0 never answers: watchdog.
      wait_cfg[0] = 255;
      do_req(1'b1, 1'b0, 21'(0 << REG_AW), 32'd0, 1'b0);
      // Unmapped slot, then ambiguous opcode.
      do_req(1'b1, 1'b0, 21'((5 << REG_AW) | 1), 32'd0, 1'b0);
      do_req(1'b1, 1'b1, 21'((2 << REG_AW) | 1), 32'd0, 1'b0);
      // Requests and foreign slot_ready during a waited access are ignored.
      wait_cfg[2] = 3;
      do_req(1'b1, 1'b0, 21'((2 << REG_AW) | 9), 32'd0, 1'b1);

      // Randomized traffic, including ignored upper address bits.
      for (int t = 0; t < 150; t++) begin
         logic [ADDR_W-1:0] a;
         logic r;
         logic w;
         int s;
         a = ADDR_W'($urandom);
         s = int'(a[REG_AW +: 6]);
         wait_cfg[s] = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 5));
         slot_mem[s] = $urandom;
         r = 1'($urandom_range(0, 1));
         w = ($urandom_range(0, 9) == 0) ? r : ~r;
         do_req(r, w, a, $urandom, bit'($urandom_range(0, 1)));
      end

      // Reset in the middle of an access.
      wait_cfg[6] = 10;
      @(negedge clk);
      mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_wr = 1'b0; mmio_addr = 21'(6 << REG_AW);
      @(posedge clk); #1;
      mmio_cs = 1'b0; mmio_rd = 1'b0;
      chk("mid_cs", 64'(slot_cs), 64'd1 << 6);
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_cs",     64'(slot_cs), 64'd0);
      chk("mid_rst_strobe", 64'({slot_rd, slot_wr}), 64'd0);
      chk("mid_rst_ready",  64'(mmio_ready), 64'd0);
      chk("mid_rst_busy",   64'(busy), 64'd0);
      chk("mid_rst_errcnt", 64'(err_cnt), 64'd0);
      exp_err_cnt = 0;
      @(negedge clk); reset = 1'b1;
      begin
         int seen;
         seen = 0;
         repeat (12) begin
            @(posedge clk); #1;
            if (mmio_ready) seen++;
         end
         chk("mid_rst_noresp", 64'(seen), 64'd0);
      end
      wait_cfg[6] = 1;
      do_req(1'b1, 1'b0, 21'(6 << REG_AW), 32'd0, 1'b0);

      // Saturation of the error counter.
      for (int t = 0; t < 300; t++) begin
         do_req(1'b1, 1'b0, 21'((40 << REG_AW) | (t % 32)), 32'd0, 1'b0);
      end
      chk("err_cnt_sat", 64'(err_cnt), 64'd255);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mmio_ws_controller.md
Name: mmio_ws_controller

Overview:
Next-generation MMIO slot controller. It decodes the processor MMIO bus into N_SLOT peripheral slots. Unlike the current zero-wait controller, it supports per-slot wait states through a slot_ready handshake, a timeout watchdog and an unmapped-slot mask. It reports bus errors and registers the read data, and it sits between the CPU bus bridge and the peripheral slots (timer, UART, GPIO, ...).

Parameters:
N_SLOT, 64, number of slots; power of 2, 2..64
REG_AW, 5, register address bits per slot
ADDR_W, 21, MMIO address width; bits above REG_AW+log2(N_SLOT) are ignored
SLOT_MASK, all ones (N_SLOT bits), bit i=1 means slot i is populated
TIMEOUT, 15, maximum wait cycles in ACCESS before an error; 1..255
UNMAP_DATA, 32'hFFFFFFFF, read data returned on any error

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
mmio_cs  in  1  request valid (sampled only in IDLE)
mmio_wr  in  1  write request
mmio_rd  in  1  read request
mmio_addr  in  ADDR_W  byte/word address: {slot, reg}
mmio_wr_data  in  32  write data
mmio_rd_data  out  32  read data, valid while mmio_ready=1
mmio_ready  out  1  one-cycle completion pulse
mmio_err  out  1  qualifies mmio_ready: access failed
busy  out  1  high in ACCESS/RESP
err_cnt  out  8  saturating count of errored accesses
slot_cs  out  N_SLOT  one-hot slot select
slot_rd  out  1  read strobe to selected slot
slot_wr  out  1  write strobe to selected slot
slot_addr  out  REG_AW  register offset
slot_wr_data  out  32  write data to slot
slot_rd_data  in  N_SLOT*32  flattened; slot i at [32*i +: 32]
slot_ready  in  N_SLOT  slot i completes its access

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE. slot_cs=0, slot_rd=0, slot_wr=0, slot_addr=0, slot_wr_data=0, mmio_rd_data=0, mmio_ready=0, mmio_err=0, busy=0, err_cnt=0, wait counter=0. Reset mid-access abandons the access with no mmio_ready pulse.
- Decode: idx=mmio_addr[REG_AW +: log2(N_SLOT)]; reg=mmio_addr[REG_AW-1:0]. Both are latched at acceptance.
- States: IDLE, ACCESS, RESP.
- IDLE, mmio_cs=1 at edge k: latch op, idx, reg and wr_data; busy=1 from k.
  - Legal access (exactly one of rd/wr, and SLOT_MASK[idx]=1): go to ACCESS; counter=0.
  - Otherwise (rd=wr, or unmapped slot): go directly to RESP with err=1. No slot strobe is ever asserted.
- ACCESS: slot_cs[idx]=1, slot_rd/slot_wr=op, and slot_addr/slot_wr_data are held stable for the whole state.
  - slot_ready[idx]=1: capture slot_rd_data[idx] (writes capture 0); go to RESP with err=0.
  - Else if counter==TIMEOUT-1: go to RESP with err=1 and rd_data=UNMAP_DATA.
  - Else counter+1.
  - slot_ready of non-selected slots is ignored.
- RESP: mmio_ready=1 for exactly one cycle, mmio_err=err, mmio_rd_data=captured data (UNMAP_DATA on any error); then go to IDLE.
  - err_cnt increments on entry to RESP with err=1, saturating at 255.
  - mmio_rd_data holds its value after RESP until the next completion.
- Latency: request at edge k with zero-wait slot (ready combinationally in the first ACCESS cycle) gives mmio_ready at edge k+2. Each wait cycle adds 1. Error-path latency is k+1.
- Requests while busy=1 are ignored (not queued); the master must wait for mmio_ready.
- Back-to-back: a new request may be sampled in the cycle after RESP. Throughput is 1 access per 3 cycles at zero wait.

Test Plan:
- Zero-wait read, slot 3 (ready tied 1, data 32'hA5A5_0003), addr={3,reg 2} -> slot_cs=0x8, slot_addr=2, mmio_ready at k+2, rd_data=32'hA5A5_0003, err=0.
- Write with 4 wait states to slot 1, data 32'h1234 -> slot_wr and slot_wr_data stable 5 cycles, single slot_wr access, ready at k+6, err=0.
- Slot never ready, TIMEOUT=15 -> strobes for exactly 15 cycles, ready at k+16, err=1, rd_data=32'hFFFFFFFF, err_cnt=1.
- SLOT_MASK bit 5=0, read slot 5; then rd=wr=1 request -> no slot_cs ever, ready at k+1 each, err=1, err_cnt=2; 300 such errors -> err_cnt=255.
- mmio_cs pulsed during ACCESS, and a non-selected slot_ready pulsed -> ignored; exactly one completion for the original request.
- reset=0 during ACCESS -> next cycle all slot strobes 0, no mmio_ready, err_cnt=0; next request completes normally.
